// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART register-bus arbiter slice.
//   arb_state_t : FSM state encoding (IDLE, ACCESS, ACK)
//   M0 / M1     : master index constants used for grant and last_grant
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter
// Combinational two-way winner selection. The parent registers the result.
// Ports:
//   req[1:0]    in  request from master 1 (bit 1) and master 0 (bit 0)
//   last_grant  in  master served by the previous access
//   lock_active in  arbiter is locked to lock_owner
//   lock_owner  in  master holding the lock
//   valid       out a winner exists this cycle
//   winner      out index of the winning master
// Parameter FIXED_PRIO: 0 = round-robin, 1 = master 0 wins ties.
module uart_rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       lock_active,
   input  logic       lock_owner,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid  = 1'b0;
      winner = M0;
      if (lock_active) begin
         // While locked, only the owner may be granted; the other master stalls.
         valid  = req[lock_owner];
         winner = lock_owner;
      end else begin
         valid = |req;
         case (req)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            2'b11:   winner = (FIXED_PRIO != 0) ? M0 : ~last_grant;
            default: winner = M0;
         endcase
      end
   end

endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter
// Two-master arbiter in front of the UART configuration/status register block.
// Each access is IDLE -> ACCESS (one-cycle rd/wr strobe) -> ACK (one-cycle ack
// with captured read data to the granted master). All outputs are registered.
// Ports:
//   bus2ip_clk, bus2ip_rst_n            clock, asynchronous active-low reset
//   mX_req_i/wr_i/addr_i/wdata_i        master X request, direction, address, data
//   mX_ack_o/rdata_o                    master X completion pulse and read data
//   mX_lock_i                           master X lock (only with UART_ARB_LOCK_EN)
//   bus2ip_addr_o/data_o                downstream address and write data
//   bus2ip_rd_ce_o/wr_ce_o              downstream read/write strobes
//   ip2bus_data_i                       downstream combinational read data
//   arb_busy_o                          high while the FSM is not in IDLE
// Optional feature macro: UART_ARB_LOCK_EN adds master lock inputs so a master
// can perform back-to-back accesses (atomic read-modify-write).
module uart_bus_arbiter
   import uart_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic              bus2ip_clk,
   input  logic              bus2ip_rst_n,
   input  logic              m0_req_i,
   input  logic              m0_wr_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_wr_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
`ifdef UART_ARB_LOCK_EN
   input  logic              m0_lock_i,
   input  logic              m1_lock_i,
`endif
   output logic [ADDR_W-1:0] bus2ip_addr_o,
   output logic [DATA_W-1:0] bus2ip_data_o,
   output logic              bus2ip_rd_ce_o,
   output logic              bus2ip_wr_ce_o,
   input  logic [DATA_W-1:0] ip2bus_data_i,
   output logic              arb_busy_o
);

   arb_state_t  state;
   logic        grant;
   logic        wr_q;
   logic        last_grant;
   logic        arb_valid;
   logic        arb_winner;
   logic        lock_eff;
   logic        lock_owner_w;

   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef UART_ARB_LOCK_EN
   logic lock_active;
   logic lock_owner;
   logic owner_lock;
   logic granted_lock;

   assign owner_lock   = (lock_owner == M1) ? m1_lock_i : m0_lock_i;
   assign granted_lock = (grant == M1) ? m1_lock_i : m0_lock_i;
   // The lock is released as soon as the owner drops its lock input in IDLE,
   // so the release takes effect in the same arbitration cycle.
   assign lock_eff     = lock_active & owner_lock;
   assign lock_owner_w = lock_owner;
`else
   assign lock_eff     = 1'b0;
   assign lock_owner_w = M0;
`endif

   uart_rr_arbiter #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_rr_arbiter (
      .req         ({m1_req_i, m0_req_i}),
      .last_grant  (last_grant),
      .lock_active (lock_eff),
      .lock_owner  (lock_owner_w),
      .valid       (arb_valid),
      .winner      (arb_winner)
   );

   assign sel_wr    = (arb_winner == M1) ? m1_wr_i    : m0_wr_i;
   assign sel_addr  = (arb_winner == M1) ? m1_addr_i  : m0_addr_i;
   assign sel_wdata = (arb_winner == M1) ? m1_wdata_i : m0_wdata_i;

   always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
      if (!bus2ip_rst_n) begin
         state          <= IDLE;
         grant          <= M0;
         wr_q           <= 1'b0;
         last_grant     <= M1;
         m0_ack_o       <= 1'b0;
         m1_ack_o       <= 1'b0;
         m0_rdata_o     <= '0;
         m1_rdata_o     <= '0;
         bus2ip_addr_o  <= '0;
         bus2ip_data_o  <= '0;
         bus2ip_rd_ce_o <= 1'b0;
         bus2ip_wr_ce_o <= 1'b0;
         arb_busy_o     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_active    <= 1'b0;
         lock_owner     <= M0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef UART_ARB_LOCK_EN
               if (lock_active && !owner_lock) begin
                  lock_active <= 1'b0;
               end
`endif
               if (arb_valid) begin
                  grant          <= arb_winner;
                  wr_q           <= sel_wr;
                  bus2ip_addr_o  <= sel_addr;
                  // Write data is meaningless on reads; keep the bus at zero.
                  bus2ip_data_o  <= sel_wr ? sel_wdata : '0;
                  bus2ip_rd_ce_o <= ~sel_wr;
                  bus2ip_wr_ce_o <= sel_wr;
                  arb_busy_o     <= 1'b1;
                  state          <= ACCESS;
               end
            end
            ACCESS: begin
               bus2ip_rd_ce_o <= 1'b0;
               bus2ip_wr_ce_o <= 1'b0;
               // Read data is sampled at the end of the strobe cycle.
               if (grant == M0) begin
                  m0_ack_o   <= 1'b1;
                  m0_rdata_o <= wr_q ? '0 : ip2bus_data_i;
               end else begin
                  m1_ack_o   <= 1'b1;
                  m1_rdata_o <= wr_q ? '0 : ip2bus_data_i;
               end
               state <= ACK;
            end
            ACK: begin
               m0_ack_o   <= 1'b0;
               m1_ack_o   <= 1'b0;
               last_grant <= grant;
               arb_busy_o <= 1'b0;
`ifdef UART_ARB_LOCK_EN
               lock_active <= granted_lock;
               lock_owner  <= grant;
`endif
               state      <= IDLE;
            end
            default: begin
               bus2ip_rd_ce_o <= 1'b0;
               bus2ip_wr_ce_o <= 1'b0;
               m0_ack_o       <= 1'b0;
               m1_ack_o       <= 1'b0;
               arb_busy_o     <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter
// Directed bench for uart_bus_arbiter. Instance dut is round-robin and sits in
// front of a small register-file model; instance dut_fp uses fixed priority
// and reads a constant value. Lock scenario runs when UART_ARB_LOCK_EN is set.
module tb_uart_bus_arbiter;

   logic clk;
   logic rst_n;

   logic        m0_req, m0_wr, m0_ack, m1_req, m1_wr, m1_ack;
   logic [15:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [15:0] bus_addr, bus_data, ip_data;
   logic        rd_ce, wr_ce, busy;
   logic        m0_lock, m1_lock;

   logic        fp_m0_req, fp_m0_wr, fp_m0_ack, fp_m1_req, fp_m1_wr, fp_m1_ack;
   logic [15:0] fp_m0_addr, fp_m0_wdata, fp_m0_rdata, fp_m1_addr, fp_m1_wdata, fp_m1_rdata;
   logic [15:0] fp_bus_addr, fp_bus_data, fp_ip_data;
   logic        fp_rd_ce, fp_wr_ce, fp_busy;
   logic        fp_m0_lock, fp_m1_lock;

   logic [15:0] regs [4];

   int checks = 0;
   int fails  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register block model: combinational read, write on the strobe.
   assign ip_data    = regs[bus_addr[1:0]];
   assign fp_ip_data = 16'hBEEF;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs[0] <= 16'd68;
         regs[1] <= 16'h0011;
         regs[2] <= 16'h0022;
         regs[3] <= 16'h0033;
      end else if (wr_ce) begin
         regs[bus_addr[1:0]] <= bus_data;
      end
   end

   uart_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut (
      .bus2ip_clk     (clk),
      .bus2ip_rst_n   (rst_n),
      .m0_req_i       (m0_req),
      .m0_wr_i        (m0_wr),
      .m0_addr_i      (m0_addr),
      .m0_wdata_i     (m0_wdata),
      .m0_ack_o       (m0_ack),
      .m0_rdata_o     (m0_rdata),
      .m1_req_i       (m1_req),
      .m1_wr_i        (m1_wr),
      .m1_addr_i      (m1_addr),
      .m1_wdata_i     (m1_wdata),
      .m1_ack_o       (m1_ack),
      .m1_rdata_o     (m1_rdata),
`ifdef UART_ARB_LOCK_EN
      .m0_lock_i      (m0_lock),
      .m1_lock_i      (m1_lock),
`endif
      .bus2ip_addr_o  (bus_addr),
      .bus2ip_data_o  (bus_data),
      .bus2ip_rd_ce_o (rd_ce),
      .bus2ip_wr_ce_o (wr_ce),
      .ip2bus_data_i  (ip_data),
      .arb_busy_o     (busy)
   );

   uart_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
      .bus2ip_clk     (clk),
      .bus2ip_rst_n   (rst_n),
      .m0_req_i       (fp_m0_req),
      .m0_wr_i        (fp_m0_wr),
      .m0_addr_i      (fp_m0_addr),
      .m0_wdata_i     (fp_m0_wdata),
      .m0_ack_o       (fp_m0_ack),
      .m0_rdata_o     (fp_m0_rdata),
      .m1_req_i       (fp_m1_req),
      .m1_wr_i        (fp_m1_wr),
      .m1_addr_i      (fp_m1_addr),
      .m1_wdata_i     (fp_m1_wdata),
      .m1_ack_o       (fp_m1_ack),
      .m1_rdata_o     (fp_m1_rdata),
`ifdef UART_ARB_LOCK_EN
      .m0_lock_i      (fp_m0_lock),
      .m1_lock_i      (fp_m1_lock),
`endif
      .bus2ip_addr_o  (fp_bus_addr),
      .bus2ip_data_o  (fp_bus_data),
      .bus2ip_rd_ce_o (fp_rd_ce),
      .bus2ip_wr_ce_o (fp_wr_ce),
      .ip2bus_data_i  (fp_ip_data),
      .arb_busy_o     (fp_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic which, input logic req, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata);
      if (which == 1'b0) begin
         m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      m0_lock = 1'b0; m1_lock = 1'b0;
      fp_m0_req = 1'b0; fp_m0_wr = 1'b0; fp_m0_addr = 16'h0; fp_m0_wdata = 16'h0;
      fp_m1_req = 1'b0; fp_m1_wr = 1'b0; fp_m1_addr = 16'h0; fp_m1_wdata = 16'h0;
      fp_m0_lock = 1'b0; fp_m1_lock = 1'b0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_rd_ce", rd_ce, 0);
      checkOutput("rst_wr_ce", wr_ce, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_m0_ack", m0_ack, 0);
      checkOutput("rst_m1_ack", m1_ack, 0);
      checkOutput("rst_addr", bus_addr, 0);
      checkOutput("rst_m0_rdata", m0_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // m0 read of address 0 returns 68
      $display("[TB] m0 read");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'hAAAA);
      tick();
      checkOutput("rd_ce_n1", rd_ce, 1);
      checkOutput("wr_ce_n1", wr_ce, 0);
      checkOutput("addr_n1", bus_addr, 16'h0000);
      checkOutput("data_on_read", bus_data, 16'h0000);
      checkOutput("busy_n1", busy, 1);
      checkOutput("m0_ack_n1", m0_ack, 0);
      tick();
      checkOutput("rd_ce_n2", rd_ce, 0);
      checkOutput("m0_ack_n2", m0_ack, 1);
      checkOutput("m0_rdata_n2", m0_rdata, 16'd68);
      checkOutput("m1_ack_n2", m1_ack, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      checkOutput("m0_ack_n3", m0_ack, 0);
      checkOutput("busy_n3", busy, 0);

      // m1 writes 5 to address 1, then reads it back
      $display("[TB] m1 write then read");
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0001, 16'h0005);
      tick();
      checkOutput("wr_ce", wr_ce, 1);
      checkOutput("wr_rd_ce", rd_ce, 0);
      checkOutput("wr_addr", bus_addr, 16'h0001);
      checkOutput("wr_data", bus_data, 16'h0005);
      tick();
      checkOutput("wr_m1_ack", m1_ack, 1);
      checkOutput("wr_m1_rdata", m1_rdata, 16'h0000);
      checkOutput("wr_m0_ack", m0_ack, 0);
      checkOutput("wr_m0_rdata_hold", m0_rdata, 16'd68);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
      tick();
      checkOutput("rb_idle_busy", busy, 0);
      tick();
      checkOutput("rb_rd_ce", rd_ce, 1);
      tick();
      checkOutput("rb_m1_ack", m1_ack, 1);
      checkOutput("rb_m1_rdata", m1_rdata, 16'h0005);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();

      // Round-robin: both hold requests for two accesses each
      $display("[TB] round-robin contention");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("rr_addr_%0d", i), bus_addr, (i % 2 == 0) ? 16'h0000 : 16'h0001);
         checkOutput($sformatf("rr_rd_ce_%0d", i), rd_ce, 1);
         tick();
         checkOutput($sformatf("rr_m0_ack_%0d", i), m0_ack, (i % 2 == 0) ? 1 : 0);
         checkOutput($sformatf("rr_m1_ack_%0d", i), m1_ack, (i % 2 == 1) ? 1 : 0);
         if (i % 2 == 0) begin
            checkOutput($sformatf("rr_m0_rdata_%0d", i), m0_rdata, 16'd68);
         end else begin
            checkOutput($sformatf("rr_m1_rdata_%0d", i), m1_rdata, 16'h0005);
            checkOutput($sformatf("rr_m0_hold_%0d", i), m0_rdata, 16'd68);
         end
         if (i == 2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         if (i == 3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
      checkOutput("rr_end_busy", busy, 0);

      // Fixed priority: m0 holds for three accesses, m1 waits
      $display("[TB] fixed priority contention");
      fp_m0_req = 1'b1; fp_m0_addr = 16'h0002;
      fp_m1_req = 1'b1; fp_m1_addr = 16'h0003;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("fp_addr_%0d", i), fp_bus_addr, (i < 3) ? 16'h0002 : 16'h0003);
         checkOutput($sformatf("fp_rd_ce_%0d", i), fp_rd_ce, 1);
         tick();
         checkOutput($sformatf("fp_m0_ack_%0d", i), fp_m0_ack, (i < 3) ? 1 : 0);
         checkOutput($sformatf("fp_m1_ack_%0d", i), fp_m1_ack, (i == 3) ? 1 : 0);
         if (i == 2) fp_m0_req = 1'b0;
         if (i == 3) begin
            checkOutput("fp_m1_rdata", fp_m1_rdata, 16'hBEEF);
            fp_m1_req = 1'b0;
         end
         tick();
      end

      // Reset during ACCESS aborts the transfer
      $display("[TB] reset during access");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
      tick();
      checkOutput("abort_rd_ce_before", rd_ce, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_rd_ce", rd_ce, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_m1_ack", m1_ack, 0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      checkOutput("abort_no_ack", m1_ack, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
      tick();
      checkOutput("post_rst_addr", bus_addr, 16'h0000);
      checkOutput("post_rst_rd_ce", rd_ce, 1);
      tick();
      checkOutput("post_rst_m0_ack", m0_ack, 1);
      checkOutput("post_rst_m1_ack", m1_ack, 0);
      checkOutput("post_rst_m0_rdata", m0_rdata, 16'd68);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();

`ifdef UART_ARB_LOCK_EN
      // m1 locked read-modify-write while m0 is requesting
      $display("[TB] locked read-modify-write");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
      m1_lock = 1'b1;
      tick();
      checkOutput("lk_rd_addr", bus_addr, 16'h0001);
      tick();
      checkOutput("lk_rd_m1_ack", m1_ack, 1);
      checkOutput("lk_rd_m1_rdata", m1_rdata, 16'h0011);
      checkOutput("lk_rd_m0_ack", m0_ack, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0001, 16'h0007);
      tick();
      checkOutput("lk_idle_busy", busy, 0);
      tick();
      checkOutput("lk_wr_ce", wr_ce, 1);
      checkOutput("lk_wr_addr", bus_addr, 16'h0001);
      checkOutput("lk_wr_data", bus_data, 16'h0007);
      m1_lock = 1'b0;
      tick();
      checkOutput("lk_wr_m1_ack", m1_ack, 1);
      checkOutput("lk_wr_m0_ack", m0_ack, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      tick();
      checkOutput("lk_m0_addr", bus_addr, 16'h0000);
      checkOutput("lk_m0_rd_ce", rd_ce, 1);
      tick();
      checkOutput("lk_m0_ack", m0_ack, 1);
      checkOutput("lk_m0_rdata", m0_rdata, 16'd68);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Two-master arbiter for the on-chip register bus that feeds the UART configuration/status register block.
- Master 0 is the host CPU port; master 1 is a local requester, e.g. a UART command bridge or self-test engine.
- Grants one master at a time, drives a single-cycle read or write strobe downstream, captures read data, and returns a one-cycle ack with data to the granted master.

Parameters:
- ADDR_W, 16, address width of masters and downstream bus.
- DATA_W, 16, data width of masters and downstream bus.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins simultaneous requests.

Ports:
- bus2ip_clk  in  1  single clock.
- bus2ip_rst_n  in  1  asynchronous active-low reset.
- m0_req_i  in  1  master 0 access request, level.
- m0_wr_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_wdata_i  in  DATA_W  master 0 write data.
- m0_ack_o  out  1  one-cycle completion pulse.
- m0_rdata_o  out  DATA_W  read data, valid while m0_ack_o is high.
- m1_req_i, m1_wr_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o: same as master 0, for master 1.
- bus2ip_addr_o  out  ADDR_W  downstream address.
- bus2ip_data_o  out  DATA_W  downstream write data.
- bus2ip_rd_ce_o  out  1  downstream read strobe, active high.
- bus2ip_wr_ce_o  out  1  downstream write strobe, active high.
- ip2bus_data_i  in  DATA_W  downstream combinational read data.
- arb_busy_o  out  1  high while the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - all acks, strobes and arb_busy_o = 0;
  - all data/address outputs = 0;
  - FSM = IDLE;
  - last_grant = 1, so master 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - Samples both requests.
  - If either is high: choose the winner, latch grant, addr, wdata and wr into registers, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - bus2ip_rd_ce_o or bus2ip_wr_ce_o is high, never both.
  - bus2ip_addr_o and bus2ip_data_o hold the latched values.
  - ip2bus_data_i is captured at the end of this cycle on reads.
  - Write data is ignored on reads.
- ACK (one cycle):
  - The granted master's ack_o is high and its rdata_o holds the captured value (0 after a write).
  - The other master's ack is 0; its rdata holds its last value.
  - Update last_grant, go to IDLE.
- Latency: request sampled in cycle N gives a strobe in N+1 and an ack in N+2. Next grant is sampled no earlier than N+3.
- Handshake rules:
  - A master holds req, wr, addr and wdata stable until it sees ack.
  - A master drops req in the cycle after ack unless it wants another access.
  - Requests seen in ACCESS or ACK are ignored until IDLE.
- Arbitration:
  - Only one request high: that master wins.
  - Both high, FIXED_PRIO = 0: the master that is not last_grant wins.
  - Both high, FIXED_PRIO = 1: master 0 wins.
- Back-to-back requests from both masters with round-robin alternate grants; maximum wait is one access (3 cycles).
- Reset asserted mid-operation aborts the transaction. No ack is issued; strobes drop immediately (asynchronously).
- Outputs are never X: unused data fields are driven 0.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- When defined:
  - Adds input ports m0_lock_i and m1_lock_i, width 1.
  - If the granted master's lock is high in the ACK cycle, the arbiter stays locked to that master: the next IDLE accepts only that master's req.
  - The lock releases when the master is in IDLE with lock low, or with req low and lock low.
  - This allows atomic read-modify-write of the config register.
  - The other master stalls while locked.
- When undefined: the lock ports do not exist and arbitration is purely as above.

Decomposition:
- Package uart_arb_pkg:
  - FSM state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2);
  - master index constants M0 = 1'b0, M1 = 1'b1.
- One sub-module, uart_rr_arbiter:
  - combinational 2-way winner selection from req[1:0], last_grant, FIXED_PRIO and the lock state;
  - the winner is registered in the parent.

Test Plan:
- After reset, m0 read at address 0x0000 (register block returns 68) -> bus2ip_rd_ce_o high for exactly one cycle, 1 cycle after req; m0_ack_o 2 cycles after req; m0_rdata_o = 16'd68.
- m1 writes 0x0005 to address 0x0001 -> bus2ip_wr_ce_o pulse with addr 0x0001 and data 0x0005; m1_ack_o with m1_rdata_o = 0; a following m1 read returns 0x0005.
- m0 and m1 request in the same cycle, held 4 accesses, FIXED_PRIO = 0 -> grant order m0, m1, m0, m1, each ack 3 cycles apart.
- Same stimulus with FIXED_PRIO = 1, m0 keeps requesting -> m0 always granted; m1 granted only after m0 drops req.
- Reset pulsed during the ACCESS cycle -> strobes go 0 immediately; no ack; arb_busy_o = 0; the next request is served normally with m0 priority.
- With UART_ARB_LOCK_EN: m1 does a locked read then write to 0x0001 while m0 is requesting -> m0 is not granted until m1's lock drops; m1's two accesses are contiguous.
